// File: rtl/branch_predictor.sv
// branch_predictor: table of 2-bit saturating counters indexed by PC, trained from ROB commit records.
// Define GSHARE_EN to XOR a commit-trained global history register into the lookup and update indices.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int HIST_BITS  = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] query_pc,
  output logic        pred_taken,
  input  logic [31:0] pc_of_branch,
  input  logic        branch_taken,
  input  logic        branch_record_valid
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return nxt;
  endfunction

  logic [1:0]            table_q [ENTRIES];
  logic                  pred_q;
  logic [INDEX_BITS-1:0] hist_idx_s;
  logic [INDEX_BITS-1:0] lkp_idx_s;
  logic [INDEX_BITS-1:0] upd_idx_s;
  logic [1:0]            ctr_d;
  logic                  unused_s;

`ifdef GSHARE_EN
  logic [HIST_BITS-1:0] ghr_q;
  logic [HIST_BITS-1:0] ghr_d;

  assign hist_idx_s = INDEX_BITS'(ghr_q);

  // History shifts in the committed direction; truncation drops the oldest bit.
  always_comb begin
    ghr_d = ghr_q;
    if (branch_record_valid) begin
      ghr_d = HIST_BITS'({ghr_q, branch_taken});
    end else begin
      ghr_d = ghr_q;
    end
  end

  // Global history register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ghr_q <= {HIST_BITS{1'b0}};
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign hist_idx_s = {INDEX_BITS{1'b0}};
`endif

  // Bits outside the index field carry no information for an untagged table.
  assign unused_s = ^{query_pc[31:INDEX_BITS+2], query_pc[1:0],
                      pc_of_branch[31:INDEX_BITS+2], pc_of_branch[1:0], HIST_BITS[0]};

  assign lkp_idx_s  = query_pc[INDEX_BITS+1:2] ^ hist_idx_s;
  assign upd_idx_s  = pc_of_branch[INDEX_BITS+1:2] ^ hist_idx_s;
  assign ctr_d      = sat_step(table_q[upd_idx_s], branch_taken);
  assign pred_taken = pred_q;

  // Counter table and registered prediction; the lookup sees pre-update state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= 2'b01;
      end
      pred_q <= 1'b0;
    end else begin
      pred_q <= table_q[lkp_idx_s][1];
      if (branch_record_valid) begin
        table_q[upd_idx_s] <= ctr_d;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed test-plan cases plus random traffic
// checked against an integer-counter reference model.
module tb_branch_predictor;

  localparam int IDX  = 6;
  localparam int HIST = 6;
  localparam int ENT  = 1 << IDX;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] query_pc = 32'h0;
  logic        pred_taken;
  logic [31:0] pc_of_branch = 32'h0;
  logic        branch_taken = 1'b0;
  logic        branch_record_valid = 1'b0;

  int checks_cnt = 0;
  int errors_cnt = 0;

  int ctr_m [ENT];
  int ghr_m = 0;

  branch_predictor #(.INDEX_BITS(IDX), .HIST_BITS(HIST)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .query_pc(query_pc),
    .pred_taken(pred_taken),
    .pc_of_branch(pc_of_branch),
    .branch_taken(branch_taken),
    .branch_record_valid(branch_record_valid)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int model_idx(input logic [31:0] pc);
    int base;
    base = int'((pc >> 2) % ENT);
    return base ^ ghr_m;
  endfunction

  // One clock: apply inputs, advance the model, compare the prediction after the edge.
  task automatic step(input string tag, input logic [31:0] q, input logic v,
                      input logic [31:0] bpc, input logic bt, input logic r);
    logic exp;
    int   ui;
    query_pc = q;
    branch_record_valid = v;
    pc_of_branch = bpc;
    branch_taken = bt;
    rst_in = r;
    @(posedge clk_in);
    if (r) begin
      for (int i = 0; i < ENT; i++) ctr_m[i] = 1;
      ghr_m = 0;
      exp = 1'b0;
    end else begin
      exp = (ctr_m[model_idx(q)] >= 2);
      if (v) begin
        ui = model_idx(bpc);
        if (bt) ctr_m[ui] = (ctr_m[ui] < 3) ? ctr_m[ui] + 1 : 3;
        else    ctr_m[ui] = (ctr_m[ui] > 0) ? ctr_m[ui] - 1 : 0;
`ifdef GSHARE_EN
        ghr_m = ((ghr_m << 1) | (bt ? 1 : 0)) % (1 << HIST);
`endif
      end
    end
    #1;
    check_eq(tag, pred_taken, exp);
  endtask

  task automatic idle(input string tag, input logic [31:0] q);
    step(tag, q, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic train(input string tag, input logic [31:0] bpc, input logic bt);
    step(tag, 32'h0000_0004, 1'b1, bpc, bt, 1'b0);
  endtask

  initial begin
    logic [31:0] rq, rb;
    logic        rv, rt, rr;

    step("reset", 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("reset_const", pred_taken, 1'b0);
    idle("q_0", 32'h0000_0000);
    check_eq("q_0_const", pred_taken, 1'b0);
    idle("q_100", 32'h0000_0100);
    check_eq("q_100_const", pred_taken, 1'b0);
    idle("q_ffc", 32'h0000_0FFC);
    check_eq("q_ffc_const", pred_taken, 1'b0);

`ifndef GSHARE_EN
    train("tr_t1", 32'h0000_1000, 1'b1);
    train("tr_t2", 32'h0000_1000, 1'b1);
    idle("sat_hi", 32'h0000_1000);
    check_eq("sat_hi_const", pred_taken, 1'b1);
    train("tr_n1", 32'h0000_1000, 1'b0);
    idle("after_n1", 32'h0000_1000);
    check_eq("after_n1_const", pred_taken, 1'b1);
    train("tr_n2", 32'h0000_1000, 1'b0);
    idle("after_n2", 32'h0000_1000);
    check_eq("after_n2_const", pred_taken, 1'b0);

    step("rbw_same", 32'h0000_1000, 1'b1, 32'h0000_1000, 1'b1, 1'b0);
    check_eq("rbw_same_const", pred_taken, 1'b0);
    idle("rbw_next", 32'h0000_1000);
    check_eq("rbw_next_const", pred_taken, 1'b1);

    train("alias_t1", 32'h0000_0100, 1'b1);
    train("alias_t2", 32'h0000_0100, 1'b1);
    idle("alias_200", 32'h0000_0200);
    check_eq("alias_200_const", pred_taken, 1'b1);
    idle("alias_104", 32'h0000_0104);
    check_eq("alias_104_const", pred_taken, 1'b0);

    step("rst_upd", 32'h0000_1000, 1'b1, 32'h0000_1000, 1'b1, 1'b1);
    idle("rst_q1", 32'h0000_1000);
    check_eq("rst_q1_const", pred_taken, 1'b0);
    idle("rst_q2", 32'h0000_1000);
    check_eq("rst_q2_const", pred_taken, 1'b0);
`else
    train("gs_t1", 32'h0000_0040, 1'b1);
    train("gs_t2", 32'h0000_0040, 1'b1);
    train("gs_t3", 32'h0000_0040, 1'b1);
    idle("gs_q40", 32'h0000_0040);
    check_eq("gs_q40_const", pred_taken, 1'b0);
    idle("gs_q58", 32'h0000_0058);
    check_eq("gs_q58_const", pred_taken, 1'b1);
    step("gs_rst", 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
`endif

    for (int n = 0; n < 3000; n++) begin
      rq = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = query_pc;
      rv = ($urandom_range(0, 2) != 0);
      rt = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 299) == 0);
      step("rand", rq, rv, rb, rt, rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
